// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - redirect event and fetch-control signal bundle
interface branch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall_if;
    logic             trap_req;
    logic [XLEN-1:0]  trap_vector;
    logic             ex_valid;
    logic             ex_branch_taken;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_branch_target;
    logic [XLEN-1:0]  ex_pc;
    logic             id_jal_valid;
    logic [XLEN-1:0]  id_jal_target;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             redirect_pending;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output stall_if, trap_req, trap_vector, ex_valid, ex_branch_taken,
               ex_pred_taken, ex_branch_target, ex_pc, id_jal_valid, id_jal_target,
        input  redirect_valid, redirect_pc, flush_if, flush_id, flush_ex,
               redirect_pending, mispredict_cnt
    );

    modport slave (
        input  stall_if, trap_req, trap_vector, ex_valid, ex_branch_taken,
               ex_pred_taken, ex_branch_target, ex_pc, id_jal_valid, id_jal_target,
        output redirect_valid, redirect_pc, flush_if, flush_id, flush_ex,
               redirect_pending, mispredict_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect arbiter with stall hold and mispredict counter
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SHADOW} state_t;
    // Encoded in priority order so a numeric compare gives "strictly higher".
    typedef enum logic [1:0] {CLS_NONE, CLS_JAL, CLS_MISP, CLS_TRAP} cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, ev_cls;
    logic [XLEN-1:0]  pc_q, pc_d, ev_target, ex_correct_pc;
    logic [2:0]       fl_q, fl_d;
    logic             valid_q, valid_d, pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mispredict, take, cnt_inc;

    function automatic logic [2:0] flush_mask(input cls_t c);
        case (c)
            CLS_TRAP: flush_mask = 3'b111;
            CLS_MISP: flush_mask = 3'b011;
            CLS_JAL:  flush_mask = 3'b001;
            default:  flush_mask = 3'b000;
        endcase
    endfunction

    assign mispredict    = bus.ex_valid & (bus.ex_branch_taken != bus.ex_pred_taken);
    assign ex_correct_pc = bus.ex_branch_taken ? bus.ex_branch_target : bus.ex_pc + XLEN'(4);

    always_comb begin
        ev_cls    = CLS_NONE;
        ev_target = '0;
        if (bus.trap_req) begin
            ev_cls    = CLS_TRAP;
            ev_target = bus.trap_vector;
        end else if (mispredict) begin
            ev_cls    = CLS_MISP;
            ev_target = ex_correct_pc;
        end else if (bus.id_jal_valid && state_q != ST_SHADOW) begin
            // The JAL seen right after a redirect is on the wrong path.
            ev_cls    = CLS_JAL;
            ev_target = bus.id_jal_target;
        end
    end

    assign take    = (ev_cls != CLS_NONE) && (state_q != ST_HOLD || ev_cls > cls_q);
    assign cnt_inc = take && (ev_cls == CLS_MISP);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        pc_d    = pc_q;
        fl_d    = 3'b000;
        valid_d = 1'b0;
        pend_d  = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (take) begin
                    cls_d = ev_cls;
                    pc_d  = ev_target;
                    fl_d  = flush_mask(ev_cls) & ~flush_mask(cls_q);
                end
                if (!bus.stall_if) begin
                    valid_d = 1'b1;
                    state_d = ST_SHADOW;
                end else begin
                    pend_d  = 1'b1;
                end
            end
            default: begin
                if (take) begin
                    cls_d = ev_cls;
                    pc_d  = ev_target;
                    fl_d  = flush_mask(ev_cls);
                    if (bus.stall_if) begin
                        pend_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        valid_d = 1'b1;
                        state_d = ST_SHADOW;
                    end
                end else begin
                    cls_d   = CLS_NONE;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            pc_q    <= '0;
            fl_q    <= 3'b000;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            pc_q    <= pc_d;
            fl_q    <= fl_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            if (cnt_inc && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.redirect_valid   = valid_q;
    assign bus.redirect_pc      = pc_q;
    assign bus.flush_if         = fl_q[0];
    assign bus.flush_id         = fl_q[1];
    assign bus.flush_ex         = fl_q[2];
    assign bus.redirect_pending = pend_q;
    assign bus.mispredict_cnt   = cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed vector bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(4)) bus ();
    branch_redirect_ctrl #(.XLEN(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        stall;
        logic        trap;
        logic [31:0] tvec;
        logic        exv;
        logic        tk;
        logic        pr;
        logic [31:0] tgt;
        logic [31:0] expc;
        logic        jal;
        logic [31:0] jtgt;
        logic        e_val;
        logic [31:0] e_pc;
        logic [2:0]  e_fl;   // {ex, id, if}
        logic        e_pend;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall_if         = v.stall;
        bus.trap_req         = v.trap;
        bus.trap_vector      = v.tvec;
        bus.ex_valid         = v.exv;
        bus.ex_branch_taken  = v.tk;
        bus.ex_pred_taken    = v.pr;
        bus.ex_branch_target = v.tgt;
        bus.ex_pc            = v.expc;
        bus.id_jal_valid     = v.jal;
        bus.id_jal_target    = v.jtgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic val, input logic [2:0] fl,
                            input logic pend, input logic [3:0] cnt);
        chk({tag, ".valid"}, 32'(bus.redirect_valid), 32'(val));
        chk({tag, ".flush"}, 32'({bus.flush_ex, bus.flush_id, bus.flush_if}), 32'(fl));
        chk({tag, ".pend"},  32'(bus.redirect_pending), 32'(pend));
        chk({tag, ".cnt"},   32'(bus.mispredict_cnt), 32'(cnt));
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        //          stall trap tvec          exv tk pr tgt          expc          jal jtgt         val pc           fl      pend cnt
        idle     = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd0};
        vecs[0]  = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd0};
        vecs[1]  = '{0, 0, 32'h0,          1, 1, 0, 32'h100,    32'h40,       0, 32'h0,      1, 32'h100,      3'b011, 0, 4'd1};
        vecs[2]  = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd1};
        vecs[3]  = '{0, 0, 32'h0,          1, 0, 1, 32'h1234,   32'hFFFF_FFFC, 0, 32'h0,     1, 32'h0,        3'b011, 0, 4'd2};
        vecs[4]  = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd2};
        vecs[5]  = '{0, 1, 32'h8000_0000,  1, 1, 0, 32'h500,    32'h80,       1, 32'h600,    1, 32'h8000_0000, 3'b111, 0, 4'd2};
        vecs[6]  = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd2};
        vecs[7]  = '{0, 0, 32'h0,          1, 1, 1, 32'h900,    32'h90,       0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd2};
        vecs[8]  = '{1, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        1, 32'h200,    0, 32'h0,        3'b001, 1, 4'd2};
        vecs[9]  = '{1, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 1, 4'd2};
        vecs[10] = '{1, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 1, 4'd2};
        vecs[11] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      1, 32'h200,      3'b000, 0, 4'd2};
        vecs[12] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        1, 32'h700,    0, 32'h0,        3'b000, 0, 4'd2};
        vecs[13] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd2};
        vecs[14] = '{1, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        1, 32'h200,    0, 32'h0,        3'b001, 1, 4'd2};
        vecs[15] = '{1, 0, 32'h0,          1, 1, 0, 32'h300,    32'h10,       0, 32'h0,      0, 32'h0,        3'b010, 1, 4'd3};
        vecs[16] = '{1, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        1, 32'h900,    0, 32'h0,        3'b000, 1, 4'd3};
        vecs[17] = '{1, 0, 32'h0,          1, 1, 0, 32'h400,    32'h20,       0, 32'h0,      0, 32'h0,        3'b000, 1, 4'd3};
        vecs[18] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      1, 32'h300,      3'b000, 0, 4'd3};
        vecs[19] = '{0, 0, 32'h0,          1, 1, 0, 32'h440,    32'h30,       0, 32'h0,      1, 32'h440,      3'b011, 0, 4'd4};
        vecs[20] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd4};
        vecs[21] = '{1, 0, 32'h0,          1, 1, 0, 32'h600,    32'h50,       0, 32'h0,      0, 32'h0,        3'b011, 1, 4'd5};
        vecs[22] = '{0, 1, 32'h8000_0004,  0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      1, 32'h8000_0004, 3'b100, 0, 4'd5};
        vecs[23] = '{0, 0, 32'h0,          0, 0, 0, 32'h0,      32'h0,        0, 32'h0,      0, 32'h0,        3'b000, 0, 4'd5};

        drive(idle);
        tick();
        tick();
        chk_outs("reset", 1'b0, 3'b000, 1'b0, 4'd0);
        chk("reset.pc", bus.redirect_pc, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_fl, vecs[i].e_pend, vecs[i].e_cnt);
            if (vecs[i].e_val)
                chk($sformatf("vec%0d.pc", i), bus.redirect_pc, vecs[i].e_pc);
        end

        // Reset while holding: the captured redirect must never appear.
        v = idle;
        v.stall = 1'b1;
        v.jal = 1'b1;
        v.jtgt = 32'h200;
        drive(v);
        tick();
        chk_outs("hold_pre_rst", 1'b0, 3'b001, 1'b1, 4'd5);
        rst = 1'b1;
        #2;
        chk_outs("async_rst", 1'b0, 3'b000, 1'b0, 4'd0);
        drive(idle);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs($sformatf("post_rst%0d", i), 1'b0, 3'b000, 1'b0, 4'd0);
        end

        // 2^CNT_W + 3 back-to-back mispredicts.
        for (int i = 0; i < 19; i++) begin
            v = idle;
            v.exv = 1'b1;
            v.tk = 1'b1;
            v.tgt = 32'h1000 + 32'(i * 4);
            drive(v);
            tick();
            chk($sformatf("sat%0d.cnt", i), 32'(bus.mispredict_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("sat%0d.pc", i), bus.redirect_pc, 32'h1000 + 32'(i * 4));
        end
        drive(idle);
        tick();
        chk_outs("sat_end", 1'b0, 3'b000, 1'b0, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
